dual_issue_backend_decode: RTL and testbench
============================================

Name: dual_issue_backend_decode

Overview:
Two-wide in-order RV32I integer back end with an integrated decoder. It accepts a fetch packet of two instructions plus per-slot branch predictions, then decodes and executes them against a 32x32 register file. Each cycle it reports up to two commits and a branch-mispredict redirect to the front end. It sits between the fetch unit and the (future) data-cache interface.

Parameters:
None (XLEN=32, 32 architectural registers fixed).

Ports:
clock  in  1  single clock, rising edge
resetn  in  1  asynchronous, active-low reset
io_i_fetch_pack_valid  in  1  packet valid
io_i_fetch_pack_ready  out  1  packet accepted when valid&ready
io_i_fetch_pack_bits_pc  in  32  PC of insts_0; insts_1 is at pc+4
io_i_fetch_pack_bits_insts_0 / _insts_1  in  32 each  slot 0 / slot 1 instruction
io_i_fetch_pack_bits_branch_predict_packs_k_valid  in  1  slot k (k=0,1) prediction valid
io_i_fetch_pack_bits_branch_predict_packs_k_is_branch  in  1  predictor saw a control-flow instruction
io_i_fetch_pack_bits_branch_predict_packs_k_taken  in  1  predicted taken
io_i_fetch_pack_bits_branch_predict_packs_k_target  in  32  predicted target
io_dcache_io_valid  in  1  reserved; ignored in this revision
io_dcache_io_MdataIn  in  64  reserved; ignored in this revision
io_o_commit_k_valid  out  1  slot k committed this cycle
io_o_commit_k_rd  out  5  destination register
io_o_commit_k_data  out  32  value written
io_o_redirect_valid  out  1  one-cycle mispredict pulse
io_o_redirect_target  out  32  correct next PC

Behaviour:
- Reset (async, resetn=0) clears:
  - all 32 registers to 0, the decode/execute (ID/EX) register to invalid;
  - commit and redirect outputs to 0, redirect_target to 0;
  - ready to 0.
- Out of reset, ready=1 every cycle. No packet is accepted while resetn=0.
- Stage 1, edge N: an accepted packet (pc, insts, predictions) is latched into the ID/EX register.
- Stage 2, cycle N+1:
  - decode both slots, read operands from the register file, execute combinationally;
  - at edge N+1, write the regfile and register the commit outputs. Commit is visible 2 edges after acceptance.
- Supported opcodes:
  - OP-IMM and OP: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND and immediate forms; shifts use the low 5 bits.
  - LUI, AUIPC.
  - JAL/JALR: rd=pc+4. The JALR target has bit 0 cleared.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - All other encodings (loads, stores, fence, system, illegal) execute as NOP with commit_valid=0.
- Commit:
  - commit_k_valid=1 for every executed, non-killed supported instruction, including rd=x0. commit_k_valid=0 for branches.
  - Writes to x0 are discarded; x0 always reads 0.
- Intra-pair bypass: if slot 1 sources slot 0's rd (rd!=0), it uses slot 0's result. If both slots write the same rd, slot 1's value remains.
- Cross-packet: the regfile is read in stage 2 after the previous packet's write edge, so no stall or forwarding is required.
- Branch resolution, per slot:
  - actual_taken is 1 for JAL/JALR/taken conditional, else 0;
  - actual_next = target if taken, else slot_pc+4;
  - mispredict = actual_taken != (pred_valid & pred_taken), or (actual_taken & target != pred_target).
- If slot 0 is actually taken (correctly or not), slot 1 is killed: no commit, no write. Slot 1 resolves only if slot 0 is not taken.
- On mispredict of the oldest resolving slot, at the same edge:
  - redirect_valid=1 for one cycle, redirect_target=actual_next;
  - the packet being accepted at that edge is discarded.
- redirect_valid is 0 otherwise.
- Reset mid-operation aborts everything immediately; there are no partial writes.

Test Plan:
1. Hold resetn=0 for 10 cycles with valid=1 and insts 0x00508093/0x00508113 -> no commits, regs stay 0, ready=0.
2. Release reset, send 0x00508093, 0x00508113 (addi x1,x1,5; addi x2,x1,5) one cycle -> commit0 x1=5, commit1 x2=10 (bypass).
3. Next cycle send 0x00510113, 0x00510213 -> x2=15, x4=20.
4. Next cycle send 0x00110233, 0x40110133 (add x4,x2,x1; sub x2,x2,x1) -> x4=20, x2=10. Then valid=0 -> no further commits.
5. Send BEQ x0,x0,+8 at pc 0x100 in slot 0 with prediction not-taken -> redirect_valid pulses, target 0x108. Slot 1 is killed, and the packet accepted at that edge is dropped.
6. Send addi x0,x0,7 in both slots -> both commit_valid=1, x0 still reads 0. A later add x5,x0,x0 commits 0.

Source files
------------

// File: rtl/dual_issue_backend_decode.sv
// Two-wide in-order RV32I back end: stage 1 latches the fetch packet,
// stage 2 decodes, executes, writes the register file and resolves branches.
module dual_issue_backend_decode (
    input  logic        clock,
    input  logic        resetn,
    input  logic        io_i_fetch_pack_valid,
    output logic        io_i_fetch_pack_ready,
    input  logic [31:0] io_i_fetch_pack_bits_pc,
    input  logic [31:0] io_i_fetch_pack_bits_insts_0,
    input  logic [31:0] io_i_fetch_pack_bits_insts_1,
    input  logic        io_i_fetch_pack_bits_branch_predict_packs_0_valid,
    input  logic        io_i_fetch_pack_bits_branch_predict_packs_0_is_branch,
    input  logic        io_i_fetch_pack_bits_branch_predict_packs_0_taken,
    input  logic [31:0] io_i_fetch_pack_bits_branch_predict_packs_0_target,
    input  logic        io_i_fetch_pack_bits_branch_predict_packs_1_valid,
    input  logic        io_i_fetch_pack_bits_branch_predict_packs_1_is_branch,
    input  logic        io_i_fetch_pack_bits_branch_predict_packs_1_taken,
    input  logic [31:0] io_i_fetch_pack_bits_branch_predict_packs_1_target,
    input  logic        io_dcache_io_valid,
    input  logic [63:0] io_dcache_io_MdataIn,
    output logic        io_o_commit_0_valid,
    output logic [4:0]  io_o_commit_0_rd,
    output logic [31:0] io_o_commit_0_data,
    output logic        io_o_commit_1_valid,
    output logic [4:0]  io_o_commit_1_rd,
    output logic [31:0] io_o_commit_1_data,
    output logic        io_o_redirect_valid,
    output logic [31:0] io_o_redirect_target
);

    typedef struct packed {
        logic        wr;
        logic [31:0] res;
        logic        taken;
        logic [31:0] tgt;
    } ex_t;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? a - b : a + b;
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'd0, $signed(a) < $signed(b)};
            3'b011:  r = {31'd0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic ex_t execute(input logic [31:0] inst, input logic [31:0] pc,
                                    input logic [31:0] a, input logic [31:0] b);
        ex_t         r;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i, imm_u, imm_j, imm_b, pc4;
        f3    = inst[14:12];
        f7    = inst[31:25];
        imm_i = {{20{inst[31]}}, inst[31:20]};
        imm_u = {inst[31:12], 12'd0};
        imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        pc4   = pc + 32'd4;
        r     = '0;
        case (inst[6:0])
            7'b0010011: begin
                r.wr  = (f3 == 3'b001) ? (f7 == 7'd0) :
                        (f3 == 3'b101) ? (f7 == 7'd0 || f7 == 7'h20) : 1'b1;
                r.res = alu(f3, f3 == 3'b101 && inst[30], a, imm_i);
            end
            7'b0110011: begin
                r.wr  = f7 == 7'd0 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                r.res = alu(f3, inst[30], a, b);
            end
            7'b0110111: begin
                r.wr  = 1'b1;
                r.res = imm_u;
            end
            7'b0010111: begin
                r.wr  = 1'b1;
                r.res = pc + imm_u;
            end
            7'b1101111: begin
                r.wr    = 1'b1;
                r.res   = pc4;
                r.taken = 1'b1;
                r.tgt   = pc + imm_j;
            end
            7'b1100111: begin
                if (f3 == 3'b000) begin
                    r.wr    = 1'b1;
                    r.res   = pc4;
                    r.taken = 1'b1;
                    r.tgt   = (a + imm_i) & ~32'd1;
                end
            end
            7'b1100011: begin
                r.tgt = pc + imm_b;
                case (f3)
                    3'b000:  r.taken = a == b;
                    3'b001:  r.taken = a != b;
                    3'b100:  r.taken = $signed(a) < $signed(b);
                    3'b101:  r.taken = $signed(a) >= $signed(b);
                    3'b110:  r.taken = a < b;
                    3'b111:  r.taken = a >= b;
                    default: r.taken = 1'b0;
                endcase
            end
            default: ;
        endcase
        return r;
    endfunction

    logic        ready_q, ready_d;
    logic        idex_valid_q, idex_valid_d;
    logic [31:0] idex_pc_q, idex_pc_d;
    logic [31:0] idex_inst0_q, idex_inst0_d, idex_inst1_q, idex_inst1_d;
    logic        idex_pt0_q, idex_pt0_d, idex_pt1_q, idex_pt1_d;
    logic [31:0] idex_tgt0_q, idex_tgt0_d, idex_tgt1_q, idex_tgt1_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];
    logic        c0_valid_q, c0_valid_d, c1_valid_q, c1_valid_d;
    logic [4:0]  c0_rd_q, c0_rd_d, c1_rd_q, c1_rd_d;
    logic [31:0] c0_data_q, c0_data_d, c1_data_q, c1_data_d;
    logic        redir_valid_q, redir_valid_d;
    logic [31:0] redir_tgt_q, redir_tgt_d;

    ex_t         ex0, ex1;
    logic [31:0] a1, b1, next0, next1;
    logic        byp, mis0, mis1, live1, redir, accept;
    logic [4:0]  rd_0, rd_1;

    logic unused_inputs;
    assign unused_inputs = ^{io_dcache_io_valid, io_dcache_io_MdataIn,
                             io_i_fetch_pack_bits_branch_predict_packs_0_is_branch,
                             io_i_fetch_pack_bits_branch_predict_packs_1_is_branch};

    assign rd_0 = idex_inst0_q[11:7];
    assign rd_1 = idex_inst1_q[11:7];

    always_comb begin
        ex0   = execute(idex_inst0_q, idex_pc_q,
                        rf_q[idex_inst0_q[19:15]], rf_q[idex_inst0_q[24:20]]);
        // slot 1 sees slot 0's result as if the pair executed sequentially
        byp   = ex0.wr && rd_0 != 5'd0;
        a1    = (byp && idex_inst1_q[19:15] == rd_0) ? ex0.res : rf_q[idex_inst1_q[19:15]];
        b1    = (byp && idex_inst1_q[24:20] == rd_0) ? ex0.res : rf_q[idex_inst1_q[24:20]];
        ex1   = execute(idex_inst1_q, idex_pc_q + 32'd4, a1, b1);
        next0 = ex0.taken ? ex0.tgt : idex_pc_q + 32'd4;
        next1 = ex1.taken ? ex1.tgt : idex_pc_q + 32'd8;
        mis0  = (ex0.taken != idex_pt0_q) || (ex0.taken && ex0.tgt != idex_tgt0_q);
        mis1  = (ex1.taken != idex_pt1_q) || (ex1.taken && ex1.tgt != idex_tgt1_q);
        live1 = idex_valid_q && !ex0.taken;
        redir = idex_valid_q && (mis0 || (live1 && mis1));

        c0_valid_d = idex_valid_q && ex0.wr;
        c0_rd_d    = rd_0;
        c0_data_d  = ex0.res;
        c1_valid_d = live1 && ex1.wr;
        c1_rd_d    = rd_1;
        c1_data_d  = ex1.res;

        rf_d = rf_q;
        if (c0_valid_d && rd_0 != 5'd0) rf_d[rd_0] = ex0.res;
        if (c1_valid_d && rd_1 != 5'd0) rf_d[rd_1] = ex1.res;

        redir_valid_d = redir;
        redir_tgt_d   = redir ? (mis0 ? next0 : next1) : redir_tgt_q;

        ready_d      = 1'b1;
        accept       = io_i_fetch_pack_valid && ready_q;
        idex_valid_d = accept && !redir;
        idex_pc_d    = accept ? io_i_fetch_pack_bits_pc : idex_pc_q;
        idex_inst0_d = accept ? io_i_fetch_pack_bits_insts_0 : idex_inst0_q;
        idex_inst1_d = accept ? io_i_fetch_pack_bits_insts_1 : idex_inst1_q;
        idex_pt0_d   = accept ? (io_i_fetch_pack_bits_branch_predict_packs_0_valid &&
                                 io_i_fetch_pack_bits_branch_predict_packs_0_taken) : idex_pt0_q;
        idex_pt1_d   = accept ? (io_i_fetch_pack_bits_branch_predict_packs_1_valid &&
                                 io_i_fetch_pack_bits_branch_predict_packs_1_taken) : idex_pt1_q;
        idex_tgt0_d  = accept ? io_i_fetch_pack_bits_branch_predict_packs_0_target : idex_tgt0_q;
        idex_tgt1_d  = accept ? io_i_fetch_pack_bits_branch_predict_packs_1_target : idex_tgt1_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
            ready_q       <= 1'b0;
            idex_valid_q  <= 1'b0;
            idex_pc_q     <= '0;
            idex_inst0_q  <= '0;
            idex_inst1_q  <= '0;
            idex_pt0_q    <= 1'b0;
            idex_pt1_q    <= 1'b0;
            idex_tgt0_q   <= '0;
            idex_tgt1_q   <= '0;
            c0_valid_q    <= 1'b0;
            c0_rd_q       <= '0;
            c0_data_q     <= '0;
            c1_valid_q    <= 1'b0;
            c1_rd_q       <= '0;
            c1_data_q     <= '0;
            redir_valid_q <= 1'b0;
            redir_tgt_q   <= '0;
        end else begin
            rf_q          <= rf_d;
            ready_q       <= ready_d;
            idex_valid_q  <= idex_valid_d;
            idex_pc_q     <= idex_pc_d;
            idex_inst0_q  <= idex_inst0_d;
            idex_inst1_q  <= idex_inst1_d;
            idex_pt0_q    <= idex_pt0_d;
            idex_pt1_q    <= idex_pt1_d;
            idex_tgt0_q   <= idex_tgt0_d;
            idex_tgt1_q   <= idex_tgt1_d;
            c0_valid_q    <= c0_valid_d;
            c0_rd_q       <= c0_rd_d;
            c0_data_q     <= c0_data_d;
            c1_valid_q    <= c1_valid_d;
            c1_rd_q       <= c1_rd_d;
            c1_data_q     <= c1_data_d;
            redir_valid_q <= redir_valid_d;
            redir_tgt_q   <= redir_tgt_d;
        end
    end

    assign io_i_fetch_pack_ready = ready_q;
    assign io_o_commit_0_valid   = c0_valid_q;
    assign io_o_commit_0_rd      = c0_rd_q;
    assign io_o_commit_0_data    = c0_data_q;
    assign io_o_commit_1_valid   = c1_valid_q;
    assign io_o_commit_1_rd      = c1_rd_q;
    assign io_o_commit_1_data    = c1_data_q;
    assign io_o_redirect_valid   = redir_valid_q;
    assign io_o_redirect_target  = redir_tgt_q;

endmodule

// File: tb/tb_dual_issue_backend_decode.sv
// Bench for dual_issue_backend_decode: directed packets plus random
// packets checked against a sequential instruction-level model.
module tb_dual_issue_backend_decode;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        valid;
    logic        ready;
    logic [31:0] pc, inst0, inst1;
    logic        pv0, pb0, pt0, pv1, pb1, pt1;
    logic [31:0] ptg0, ptg1;
    logic        dc_valid;
    logic [63:0] dc_data;
    logic        c0v, c1v, rv;
    logic [4:0]  c0rd, c1rd;
    logic [31:0] c0d, c1d, rt;

    always #5 clock = ~clock;

    dual_issue_backend_decode dut (
        .clock(clock), .resetn(resetn),
        .io_i_fetch_pack_valid(valid), .io_i_fetch_pack_ready(ready),
        .io_i_fetch_pack_bits_pc(pc),
        .io_i_fetch_pack_bits_insts_0(inst0), .io_i_fetch_pack_bits_insts_1(inst1),
        .io_i_fetch_pack_bits_branch_predict_packs_0_valid(pv0),
        .io_i_fetch_pack_bits_branch_predict_packs_0_is_branch(pb0),
        .io_i_fetch_pack_bits_branch_predict_packs_0_taken(pt0),
        .io_i_fetch_pack_bits_branch_predict_packs_0_target(ptg0),
        .io_i_fetch_pack_bits_branch_predict_packs_1_valid(pv1),
        .io_i_fetch_pack_bits_branch_predict_packs_1_is_branch(pb1),
        .io_i_fetch_pack_bits_branch_predict_packs_1_taken(pt1),
        .io_i_fetch_pack_bits_branch_predict_packs_1_target(ptg1),
        .io_dcache_io_valid(dc_valid), .io_dcache_io_MdataIn(dc_data),
        .io_o_commit_0_valid(c0v), .io_o_commit_0_rd(c0rd), .io_o_commit_0_data(c0d),
        .io_o_commit_1_valid(c1v), .io_o_commit_1_rd(c1rd), .io_o_commit_1_data(c1d),
        .io_o_redirect_valid(rv), .io_o_redirect_target(rt)
    );

    localparam int K_ADDI = 0, K_SLTI = 1, K_SLTIU = 2, K_XORI = 3, K_ORI = 4, K_ANDI = 5;
    localparam int K_SLLI = 6, K_SRLI = 7, K_SRAI = 8;
    localparam int K_ADD = 9, K_SUB = 10, K_SLL = 11, K_SLT = 12, K_SLTU = 13;
    localparam int K_XOR = 14, K_SRL = 15, K_SRA = 16, K_OR = 17, K_AND = 18;
    localparam int K_LUI = 19, K_AUIPC = 20, K_JAL = 21, K_JALR = 22;
    localparam int K_BEQ = 23, K_BNE = 24, K_BLT = 25, K_BGE = 26, K_BLTU = 27, K_BGEU = 28;
    localparam int K_LW = 29, K_SW = 30, NK = 31;

    typedef struct {
        int          k;
        logic [4:0]  rd, rs1, rs2;
        int          imm;
        bit          pv, pt;
        logic [31:0] ptgt;
    } ins_t;

    typedef struct {
        logic [31:0] pc;
        ins_t        s0, s1;
    } pkt_t;

    typedef struct {
        bit          wr;
        logic [31:0] v;
        bit          tk;
        logic [31:0] tgt;
    } res_t;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] m_rf [32];
    bit          m_v, m_ready;
    pkt_t        m_p, idle;
    logic [108:0] m_exp, obs;

    function automatic logic [108:0] mk(bit v0, int rd0, logic [31:0] d0,
                                        bit v1, int rd1, logic [31:0] d1,
                                        bit r, logic [31:0] t);
        return {v0, v0 ? 5'(rd0) : 5'd0, v0 ? d0 : 32'd0,
                v1, v1 ? 5'(rd1) : 5'd0, v1 ? d1 : 32'd0,
                r, r ? t : 32'd0};
    endfunction

    assign obs = mk(c0v, int'(c0rd), c0d, c1v, int'(c1rd), c1d, rv, rt);

    function automatic ins_t mk_ins(int k, int rd, int rs1, int rs2, int imm);
        ins_t x;
        x.k = k; x.rd = 5'(rd); x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.imm = imm;
        x.pv = 1'b0; x.pt = 1'b0; x.ptgt = 32'd0;
        return x;
    endfunction

    function automatic logic [2:0] f3_of(int k);
        case (k)
            K_SLTI, K_SLT, K_LW, K_SW: return 3'd2;
            K_SLTIU, K_SLTU:           return 3'd3;
            K_XORI, K_XOR, K_BLT:      return 3'd4;
            K_ORI, K_OR, K_BLTU:       return 3'd6;
            K_ANDI, K_AND, K_BGEU:     return 3'd7;
            K_SLLI, K_SLL, K_BNE:      return 3'd1;
            K_SRLI, K_SRAI, K_SRL, K_SRA, K_BGE: return 3'd5;
            default:                   return 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] encode(ins_t x);
        logic [31:0] im;
        logic [2:0]  f3;
        logic [6:0]  f7;
        im = x.imm;
        f3 = f3_of(x.k);
        f7 = (x.k == K_SUB || x.k == K_SRA || x.k == K_SRAI) ? 7'h20 : 7'h00;
        if (x.k <= K_ANDI) return {im[11:0], x.rs1, f3, x.rd, 7'h13};
        if (x.k <= K_SRAI) return {f7, im[4:0], x.rs1, f3, x.rd, 7'h13};
        if (x.k <= K_AND)  return {f7, x.rs2, x.rs1, f3, x.rd, 7'h33};
        if (x.k == K_LUI)  return {im[19:0], x.rd, 7'h37};
        if (x.k == K_AUIPC) return {im[19:0], x.rd, 7'h17};
        if (x.k == K_JAL)  return {im[20], im[10:1], im[11], im[19:12], x.rd, 7'h6f};
        if (x.k == K_JALR) return {im[11:0], x.rs1, 3'b000, x.rd, 7'h67};
        if (x.k <= K_BGEU) return {im[12], im[10:5], x.rs2, x.rs1, f3, im[4:1], im[11], 7'h63};
        if (x.k == K_LW)   return {im[11:0], x.rs1, f3, x.rd, 7'h03};
        return {im[11:5], x.rs2, x.rs1, f3, im[4:0], 7'h23};
    endfunction

    // instruction semantics, read straight from the ISA description
    function automatic res_t mexec(ins_t x, logic [31:0] at);
        res_t        r;
        logic [31:0] a, b, i;
        a = m_rf[x.rs1]; b = m_rf[x.rs2]; i = x.imm;
        r.wr = 1'b1; r.v = 32'd0; r.tk = 1'b0; r.tgt = 32'd0;
        case (x.k)
            K_ADDI:  r.v = a + i;
            K_SLTI:  r.v = ($signed(a) < $signed(i)) ? 32'd1 : 32'd0;
            K_SLTIU: r.v = (a < i) ? 32'd1 : 32'd0;
            K_XORI:  r.v = a ^ i;
            K_ORI:   r.v = a | i;
            K_ANDI:  r.v = a & i;
            K_SLLI:  r.v = a << x.imm;
            K_SRLI:  r.v = a >> x.imm;
            K_SRAI:  r.v = $signed(a) >>> x.imm;
            K_ADD:   r.v = a + b;
            K_SUB:   r.v = a - b;
            K_SLL:   r.v = a << (b % 32);
            K_SLT:   r.v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            K_SLTU:  r.v = (a < b) ? 32'd1 : 32'd0;
            K_XOR:   r.v = a ^ b;
            K_SRL:   r.v = a >> (b % 32);
            K_SRA:   r.v = $signed(a) >>> (b % 32);
            K_OR:    r.v = a | b;
            K_AND:   r.v = a & b;
            K_LUI:   r.v = i << 12;
            K_AUIPC: r.v = at + (i << 12);
            K_JAL:   begin r.v = at + 4; r.tk = 1'b1; r.tgt = at + i; end
            K_JALR:  begin r.v = at + 4; r.tk = 1'b1; r.tgt = (a + i) & 32'hFFFF_FFFE; end
            K_BEQ:   begin r.wr = 1'b0; r.tk = a == b; r.tgt = at + i; end
            K_BNE:   begin r.wr = 1'b0; r.tk = a != b; r.tgt = at + i; end
            K_BLT:   begin r.wr = 1'b0; r.tk = $signed(a) < $signed(b); r.tgt = at + i; end
            K_BGE:   begin r.wr = 1'b0; r.tk = $signed(a) >= $signed(b); r.tgt = at + i; end
            K_BLTU:  begin r.wr = 1'b0; r.tk = a < b; r.tgt = at + i; end
            K_BGEU:  begin r.wr = 1'b0; r.tk = a >= b; r.tgt = at + i; end
            default: r.wr = 1'b0;
        endcase
        return r;
    endfunction

    function automatic ins_t rnd_ins(logic [31:0] at);
        ins_t x;
        int   k;
        k = $urandom_range(0, NK - 1);
        if ($urandom_range(0, 5) == 0) k = K_LUI;
        x = mk_ins(k, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0);
        if (k >= K_SLLI && k <= K_SRAI) x.imm = $urandom_range(0, 31);
        else if (k == K_LUI || k == K_AUIPC) x.imm = $urandom_range(0, 20'hFFFFF);
        else if (k == K_JAL) x.imm = (int'($urandom_range(0, 1023)) - 512) * 2;
        else if (k >= K_BEQ && k <= K_BGEU) x.imm = (int'($urandom_range(0, 255)) - 128) * 2;
        else x.imm = int'($urandom_range(0, 4095)) - 2048;
        x.pv = $urandom_range(0, 1);
        x.pt = $urandom_range(0, 1);
        x.ptgt = $urandom_range(0, 1) ? at + x.imm : $urandom;
        return x;
    endfunction

    task automatic set_inputs(input bit v, input pkt_t p);
        valid = v; pc = p.pc;
        inst0 = encode(p.s0); inst1 = encode(p.s1);
        pv0 = p.s0.pv; pb0 = p.s0.pv; pt0 = p.s0.pt; ptg0 = p.s0.ptgt;
        pv1 = p.s1.pv; pb1 = p.s1.pv; pt1 = p.s1.pt; ptg1 = p.s1.ptgt;
        dc_valid = $urandom_range(0, 1); dc_data = {$urandom, $urandom};
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_v = 1'b0; m_ready = 1'b0; m_exp = '0;
    endtask

    // drive one cycle, predict the outputs of the coming edge, sample after it
    task automatic tick(input bit v, input pkt_t p);
        res_t        r0, r1;
        bit          mis0, mis1, c1, redir;
        logic [31:0] tgt;
        set_inputs(v, p);
        r1 = '{default: 0};
        m_exp = '0; redir = 1'b0; tgt = 32'd0; c1 = 1'b0;
        if (m_v) begin
            r0 = mexec(m_p.s0, m_p.pc);
            if (r0.wr && m_p.s0.rd != 0) m_rf[m_p.s0.rd] = r0.v;
            mis0 = (r0.tk != (m_p.s0.pv && m_p.s0.pt)) || (r0.tk && r0.tgt != m_p.s0.ptgt);
            redir = mis0;
            tgt = r0.tk ? r0.tgt : m_p.pc + 4;
            if (!r0.tk) begin
                r1 = mexec(m_p.s1, m_p.pc + 4);
                c1 = r1.wr;
                if (r1.wr && m_p.s1.rd != 0) m_rf[m_p.s1.rd] = r1.v;
                mis1 = (r1.tk != (m_p.s1.pv && m_p.s1.pt)) || (r1.tk && r1.tgt != m_p.s1.ptgt);
                if (!mis0 && mis1) begin
                    redir = 1'b1;
                    tgt = r1.tk ? r1.tgt : m_p.pc + 8;
                end
            end
            m_exp = mk(r0.wr, m_p.s0.rd, r0.v, c1, m_p.s1.rd, r1.v, redir, tgt);
        end
        m_v = v && m_ready && !redir;
        m_p = p;
        @(posedge clock);
        m_ready = 1'b1;
        @(negedge clock);
    endtask

    function automatic pkt_t pk(logic [31:0] at, ins_t a, ins_t b);
        pkt_t p;
        p.pc = at; p.s0 = a; p.s1 = b;
        return p;
    endfunction

    task automatic test_reset();
        set_inputs(1'b1, pk(0, mk_ins(K_ADDI, 1, 1, 0, 5), mk_ins(K_ADDI, 2, 1, 0, 5)));
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); @(negedge clock);
            n_tests++;
            if ({ready, obs} !== '0) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: ready=%b out=%h want 0", i, ready, obs);
            end
        end
        resetn = 1'b1;
        model_reset();
        tick(1'b0, idle);
        n_tests++;
        if (ready !== 1'b1 || obs !== '0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b out=%h want ready=1 out=0", ready, obs);
        end
    endtask

    task automatic test_bypass();
        pkt_t        p[3];
        logic [108:0] want[5];
        p[0] = pk(32'h0, mk_ins(K_ADDI, 1, 1, 0, 5), mk_ins(K_ADDI, 2, 1, 0, 5));
        p[1] = pk(32'h8, mk_ins(K_ADDI, 2, 2, 0, 5), mk_ins(K_ADDI, 4, 2, 0, 5));
        p[2] = pk(32'h10, mk_ins(K_ADD, 4, 2, 1, 0), mk_ins(K_SUB, 2, 2, 1, 0));
        want[0] = '0;
        want[1] = mk(1, 1, 5, 1, 2, 10, 0, 0);
        want[2] = mk(1, 2, 15, 1, 4, 20, 0, 0);
        want[3] = mk(1, 4, 20, 1, 2, 10, 0, 0);
        want[4] = '0;
        for (int i = 0; i < 5; i++) begin
            tick(i < 3, (i < 3) ? p[i] : idle);
            n_tests++;
            if (obs !== want[i]) begin
                n_fail++;
                $display("FAIL bypass step %0d: got %h want %h", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_branch();
        pkt_t        p[6];
        logic [108:0] want[6];
        p[0] = pk(32'h100, mk_ins(K_BEQ, 0, 0, 0, 8), mk_ins(K_ADDI, 6, 0, 0, 1));
        p[0].s0.pv = 1'b1;
        p[1] = pk(32'h200, mk_ins(K_ADDI, 8, 0, 0, 3), mk_ins(K_ADDI, 9, 0, 0, 4));
        p[2] = pk(32'h300, mk_ins(K_BNE, 0, 1, 0, 16), mk_ins(K_ADDI, 11, 0, 0, 9));
        p[2].s0.pv = 1'b1; p[2].s0.pt = 1'b1; p[2].s0.ptgt = 32'h310;
        p[3] = pk(32'h310, mk_ins(K_ADD, 7, 6, 0, 0), mk_ins(K_ADD, 10, 8, 9, 0));
        p[4] = pk(32'h318, mk_ins(K_ADD, 12, 11, 0, 0), mk_ins(K_ADDI, 13, 0, 0, 1));
        want[0] = '0;
        want[1] = mk(0, 0, 0, 0, 0, 0, 1, 32'h108);
        want[2] = '0;
        want[3] = '0;
        want[4] = mk(1, 7, 0, 1, 10, 0, 0, 0);
        want[5] = mk(1, 12, 0, 1, 13, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick(i < 5, (i < 5) ? p[i] : idle);
            n_tests++;
            if (obs !== want[i]) begin
                n_fail++;
                $display("FAIL branch step %0d: got %h want %h", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_x0();
        tick(1'b1, pk(32'h400, mk_ins(K_ADDI, 0, 0, 0, 7), mk_ins(K_ADDI, 0, 0, 0, 7)));
        tick(1'b1, pk(32'h408, mk_ins(K_ADD, 5, 0, 0, 0), mk_ins(K_LW, 3, 0, 0, 0)));
        n_tests++;
        if (obs !== mk(1, 0, 7, 1, 0, 7, 0, 0)) begin
            n_fail++;
            $display("FAIL x0_commit: got %h want %h", obs, mk(1, 0, 7, 1, 0, 7, 0, 0));
        end
        tick(1'b0, idle);
        n_tests++;
        if (obs !== mk(1, 5, 0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL x0_read: got %h want %h", obs, mk(1, 5, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, pk(32'h500, mk_ins(K_ADDI, 18, 0, 0, 18), mk_ins(K_ADDI, 19, 0, 0, 19)));
        tick(1'b1, pk(32'h508, mk_ins(K_ADDI, 9, 0, 0, 9), mk_ins(K_ADDI, 15, 0, 0, 1)));
        n_tests++;
        if (obs !== mk(1, 18, 18, 1, 19, 19, 0, 0)) begin
            n_fail++;
            $display("FAIL pre_reset: got %h want %h", obs, mk(1, 18, 18, 1, 19, 19, 0, 0));
        end
        resetn = 1'b0;
        #1;
        n_tests++;
        if ({ready, obs} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: ready=%b out=%h want 0", ready, obs);
        end
        @(posedge clock); @(negedge clock);
        resetn = 1'b1;
        model_reset();
        tick(1'b0, idle);
        n_tests++;
        if (ready !== 1'b1 || obs !== '0) begin
            n_fail++;
            $display("FAIL reset_abort: ready=%b out=%h want ready=1 out=0", ready, obs);
        end
        tick(1'b1, pk(32'h600, mk_ins(K_ADD, 16, 9, 1, 0), mk_ins(K_ADD, 17, 18, 15, 0)));
        tick(1'b0, idle);
        n_tests++;
        if (obs !== mk(1, 16, 0, 1, 17, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL regs_cleared: got %h want %h", obs, mk(1, 16, 0, 1, 17, 0, 0, 0));
        end
    endtask

    task automatic test_random();
        pkt_t        p;
        logic [31:0] at;
        for (int i = 0; i < 600; i++) begin
            at = $urandom & 32'hFFFF_FFFC;
            p = pk(at, rnd_ins(at), rnd_ins(at + 4));
            tick($urandom_range(0, 4) != 0, p);
            n_tests++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs, m_exp);
            end
        end
    endtask

    initial begin
        idle = pk(32'h0, mk_ins(K_ADDI, 0, 0, 0, 0), mk_ins(K_ADDI, 0, 0, 0, 0));
        model_reset();
        set_inputs(1'b0, idle);
        @(negedge clock);
        test_reset();
        test_bypass();
        test_branch();
        test_x0();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
